// File: rtl/pipelined_adder_nbit.sv
// pipelined_adder_nbit
//   Wide unsigned adder split into STAGES = WIDTH/CHUNK carry-registered
//   stages. Stage k adds one CHUNK-bit slice and registers the low
//   (k+1)*CHUNK sum bits, its carry and the operand bits still to be added.
//   The pipeline advances as a whole whenever the output register is empty
//   or being drained, giving one add per cycle with backpressure.
//
// Optional build macro: ADDER_OVERFLOW_EN adds a registered Ovf output
//   (two's-complement signed overflow, aligned with Sum).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   A/B/Cin present this cycle
//   in_ready   adder accepts input this cycle (combinational from out_ready)
//   A, B       WIDTH-bit operands
//   Cin        carry in
//   out_valid  Sum/Cout valid
//   out_ready  downstream accepts result
//   Sum        (A + B + Cin) mod 2^WIDTH, registered
//   Cout       carry out of bit WIDTH-1, registered
//   Ovf        (ADDER_OVERFLOW_EN only) signed overflow, registered
module pipelined_adder_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
  localparam int STAGES     = WIDTH / SAFE_CHUNK;

  if (CHUNK < 1 || WIDTH < 1 || (WIDTH % SAFE_CHUNK) != 0) begin : g_param_check
    $fatal(1, "pipelined_adder_nbit: WIDTH must be a positive multiple of CHUNK >= 1");
  end

  // Global stall: every stage moves together, no bubble collapsing.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Operand pipeline: g_op[j] holds the A/B bits not yet consumed when a
  // transaction sits in front of stage j. Its low CHUNK bits feed stage j,
  // the rest are passed on to g_op[j+1].
  for (genvar j = 1; j < STAGES; j++) begin : g_op
    localparam int OW = WIDTH - j * CHUNK;
    logic [OW-1:0] a_d, b_d;
    logic [OW-1:0] a_q, b_q;

    if (j == 1) begin : g_src_in
      assign a_d = A[WIDTH-1:CHUNK];
      assign b_d = B[WIDTH-1:CHUNK];
    end else begin : g_src_prev
      assign a_d = g_op[j-1].a_q[OW+CHUNK-1:CHUNK];
      assign b_d = g_op[j-1].b_q[OW+CHUNK-1:CHUNK];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
      end else if (advance) begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SW = (k + 1) * CHUNK;
    logic [CHUNK-1:0] op_a, op_b;
    logic             cin;
    logic [CHUNK:0]   chunk_sum;
    logic             valid_d;
    logic [SW-1:0]    sum_d;
    logic             valid_q;
    logic             carry_q;
    logic [SW-1:0]    sum_q;

    if (k == 0) begin : g_first
      assign op_a    = A[CHUNK-1:0];
      assign op_b    = B[CHUNK-1:0];
      assign cin     = Cin;
      assign valid_d = in_valid;
      assign sum_d   = chunk_sum[CHUNK-1:0];
    end else begin : g_next
      assign op_a    = g_op[k].a_q[CHUNK-1:0];
      assign op_b    = g_op[k].b_q[CHUNK-1:0];
      assign cin     = g_stage[k-1].carry_q;
      assign valid_d = g_stage[k-1].valid_q;
      assign sum_d   = {chunk_sum[CHUNK-1:0], g_stage[k-1].sum_q};
    end

    assign chunk_sum = {1'b0, op_a} + {1'b0, op_b} + {{CHUNK{1'b0}}, cin};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= valid_d;
        carry_q <= chunk_sum[CHUNK];
        sum_q   <= sum_d;
      end
    end
  end

  assign Sum       = g_stage[STAGES-1].sum_q;
  assign Cout      = g_stage[STAGES-1].carry_q;
  assign out_valid = g_stage[STAGES-1].valid_q;

`ifdef ADDER_OVERFLOW_EN
  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  logic ovf_d;
  logic ovf_q;
  assign ovf_d = g_stage[STAGES-1].op_a[CHUNK-1] ^ g_stage[STAGES-1].op_b[CHUNK-1]
               ^ g_stage[STAGES-1].chunk_sum[CHUNK-1] ^ g_stage[STAGES-1].chunk_sum[CHUNK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
module tb_pipelined_adder_nbit;

  localparam int W   = 16;
  localparam int LAT = 4;  // 16 / 4 stages

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, Cin, Cout;
  logic [W-1:0]  A, B, Sum;

  logic          in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4;
  logic [3:0]    a4, b4, sum4;

`ifdef ADDER_OVERFLOW_EN
  logic          Ovf, ovf4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_adder_nbit #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout)
`ifdef ADDER_OVERFLOW_EN
    , .Ovf(Ovf)
`endif
  );

  pipelined_adder_nbit #(.WIDTH(4), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(a4), .B(b4), .Cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .Sum(sum4), .Cout(cout4)
`ifdef ADDER_OVERFLOW_EN
    , .Ovf(ovf4)
`endif
  );

  // Reference: full-precision unsigned add, {Cout, Sum}.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (Sum !== 16'h0000) begin bad++; $display("FAIL reset_sum: got %h want 0000", Sum); end
    total++; if (Cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", Cout); end
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_out_valid4: got %b want 0", out_valid4); end
    step; step;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
    step;
  endtask

  task automatic test_latency;
    in_valid = 1'b1; A = 16'h0001; B = 16'h0000; Cin = 1'b0; out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      total++;
      if (out_valid !== (i == LAT)) begin
        bad++; $display("FAIL latency_valid_%0d: got %b want %b", i, out_valid, (i == LAT));
      end
      if (i < LAT) step;
    end
    total++; if (Sum !== 16'h0001) begin bad++; $display("FAIL latency_sum: got %h want 0001", Sum); end
    total++; if (Cout !== 1'b0) begin bad++; $display("FAIL latency_cout: got %b want 0", Cout); end
    step;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_carry;
    logic [W:0] exp_q[$];
    logic [W:0] e;
    int got, n;
    out_ready = 1'b1;
    in_valid = 1'b1; A = 16'hFFFF; B = 16'h0001; Cin = 1'b0;
    exp_q.push_back(17'h10000);
    step;
    A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
    exp_q.push_back(17'h1FFFF);
    step;
    in_valid = 1'b0;
    got = 0; n = 0;
    while (got < 2 && n < 12) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        total++;
        if ({Cout, Sum} !== e) begin
          bad++; $display("FAIL carry_result_%0d: got %b/%h want %b/%h", got, Cout, Sum, e[W], e[W-1:0]);
        end
        got++;
      end
      step; n++;
    end
    total++; if (got != 2) begin bad++; $display("FAIL carry_count: got %0d want 2", got); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] va[3];
    logic [W-1:0] vb[3];
    logic         vc[3];
    logic [W:0]   exp_q[$];
    logic [W:0]   e;
    int got, n;
    va = '{16'h1234, 16'hA5A5, 16'h8000};
    vb = '{16'h1111, 16'h5A5A, 16'h8000};
    vc = '{1'b0, 1'b1, 1'b0};
    exp_q = '{17'h02345, 17'h10000, 17'h10000};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A = va[i]; B = vb[i]; Cin = vc[i];
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_%0d: got %b want 1", i, in_ready); end
      step;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin step; n++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_timeout: got %b want 1", out_valid); end
    // Offer a new operand during the stall; it must not be taken.
    in_valid = 1'b1; A = 16'h0F0F; B = 16'h0101; Cin = 1'b0;
    for (int s = 0; s < 2; s++) begin
      #1;
      total++;
      if (out_valid !== 1'b1 || Sum !== 16'h2345 || Cout !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_stall_%0d: got v=%b s=%h c=%b rdy=%b want v=1 s=2345 c=0 rdy=0",
                 s, out_valid, Sum, Cout, in_ready);
      end
      step;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    got = 0; n = 0;
    while (got < 3 && n < 20) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        total++;
        if ({Cout, Sum} !== e) begin
          bad++; $display("FAIL b2b_result_%0d: got %b/%h want %b/%h", got, Cout, Sum, e[W], e[W-1:0]);
        end
        got++;
      end
      step; n++;
    end
    total++; if (got != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", got); end
    for (int i = 0; i < 6; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_extra_%0d: got %b want 0", i, out_valid); end
      step;
    end
  endtask

  task automatic test_reset_mid;
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A = 16'h1111 * 16'(i + 1); B = 16'h2222; Cin = 1'b1;
      step;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin step; n++; end
    total++; if (out_valid !== 1'b1 || Sum !== 16'h3334) begin
      bad++; $display("FAIL rstmid_before: got v=%b s=%h want v=1 s=3334", out_valid, Sum);
    end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    total++; if (Sum !== 16'h0000 || Cout !== 1'b0) begin
      bad++; $display("FAIL rstmid_sum: got %b/%h want 0/0000", Cout, Sum);
    end
    step;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale_%0d: got %b want 0", i, out_valid); end
      step;
    end
  endtask

  task automatic test_random;
    logic [W:0] exp_q[$];
    logic [W:0] e;
    for (int i = 0; i < 400; i++) begin
      in_valid  = (i < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
      out_ready = (i < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
      A   = 16'($urandom);
      B   = 16'($urandom);
      Cin = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (in_ready !== (!out_valid || out_ready)) begin
        bad++; $display("FAIL rand_in_ready_%0d: got %b want %b", i, in_ready, (!out_valid || out_ready));
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_unexpected_%0d: got %b/%h want no output", i, Cout, Sum);
        end else begin
          e = exp_q.pop_front();
          if ({Cout, Sum} !== e) begin
            bad++; $display("FAIL rand_result_%0d: got %b/%h want %b/%h", i, Cout, Sum, e[W], e[W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_add(A, B, Cin));
      step;
    end
    in_valid = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_width4;
    out_ready4 = 1'b1;
    in_valid4 = 1'b1; a4 = 4'b1010; b4 = 4'b0011; cin4 = 1'b0;
    #1;
    total++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      bad++; $display("FAIL w4_pre: got rdy=%b v=%b want rdy=1 v=0", in_ready4, out_valid4);
    end
    step;
    a4 = 4'b1101; b4 = 4'b1010; cin4 = 1'b1;
    total++; if (out_valid4 !== 1'b1 || sum4 !== 4'b1101 || cout4 !== 1'b0) begin
      bad++; $display("FAIL w4_first: got v=%b %b/%b want v=1 0/1101", out_valid4, cout4, sum4);
    end
    step;
    in_valid4 = 1'b0;
    total++; if (out_valid4 !== 1'b1 || sum4 !== 4'b1000 || cout4 !== 1'b1) begin
      bad++; $display("FAIL w4_second: got v=%b %b/%b want v=1 1/1000", out_valid4, cout4, sum4);
    end
    step;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL w4_drop: got %b want 0", out_valid4); end
  endtask

`ifdef ADDER_OVERFLOW_EN
  task automatic test_overflow;
    logic [W-1:0] va[2];
    logic [W-1:0] vb[2];
    logic [W:0]   e;
    logic         eo;
    int got, n;
    va = '{16'h7FFF, 16'hFFFF};
    vb = '{16'h0001, 16'h0001};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; A = va[i]; B = vb[i]; Cin = 1'b0;
      step;
    end
    in_valid = 1'b0;
    got = 0; n = 0;
    while (got < 2 && n < 12) begin
      if (out_valid) begin
        e  = ref_add(va[got], vb[got], 1'b0);
        // Signed overflow: same-sign operands giving an opposite-sign result.
        eo = (va[got][W-1] == vb[got][W-1]) && (e[W-1] != va[got][W-1]);
        total++;
        if ({Cout, Sum} !== e || Ovf !== eo) begin
          bad++; $display("FAIL ovf_result_%0d: got %b/%h ovf=%b want %b/%h ovf=%b",
                          got, Cout, Sum, Ovf, e[W], e[W-1:0], eo);
        end
        got++;
      end
      step; n++;
    end
    total++; if (got != 2) begin bad++; $display("FAIL ovf_count: got %0d want 2", got); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
    test_reset;
    test_latency;
    test_carry;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_width4;
`ifdef ADDER_OVERFLOW_EN
    test_overflow;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
